// File: rtl/sram_march_bist_ctrl_if.sv
// BIST side-port bundle between the March controller and one SRAM port.
// master = controller (initiator), slave = macro port.
interface sram_march_bist_ctrl_if #(
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_DATA_WIDTH = 32
);
    logic                    en;
    logic                    men;
    logic                    wen;
    logic                    ren;
    logic [P_ADDR_WIDTH-1:0] addr;
    logic [P_DATA_WIDTH-1:0] din;
    logic [P_DATA_WIDTH-1:0] bm;
    logic [P_DATA_WIDTH-1:0] dout;

    modport master (
        output en, men, wen, ren, addr, din, bm,
        input  dout
    );

    modport slave (
        input  en, men, wen, ren, addr, din, bm,
        output dout
    );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST engine for one port of the 2-port byte-mask SRAM family.
// Issues 10N operations, compares reads two edges later, logs the first fail.
module sram_march_bist_ctrl #(
    parameter int P_ADDR_WIDTH    = 10,
    parameter int P_DATA_WIDTH    = 32,
    parameter int P_ERR_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [P_ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [P_ADDR_WIDTH-1:0]    fail_addr,
    output logic [2:0]                 fail_elem,
    output logic [P_DATA_WIDTH-1:0]    fail_data,
    sram_march_bist_ctrl_if.master     bist
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [P_DATA_WIDTH-1:0] ONES     = '1;

    state_t                  state, n_state;
    logic [2:0]              elem, n_elem;
    logic [P_ADDR_WIDTH-1:0] addr, n_addr;
    logic                    phase, n_phase;
    logic                    drain, n_drain;

    logic                    en_q, men_q, wen_q, ren_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] din_q, bm_q;
    logic                    busy_q, done_q;

    logic                    s1_vld;
    logic [P_DATA_WIDTH-1:0] s1_exp;
    logic [P_ADDR_WIDTH-1:0] s1_addr;
    logic [2:0]              s1_elem;

    logic last_op, last_addr, n_run, n_rd, mism;

    function automatic logic is_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic rd_ones(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    function automatic logic wr_ones(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    // E0 is write-only, E5 read-only; E1..E4 are read then write.
    function automatic logic is_read(input logic [2:0] e, input logic ph);
        return (e != 3'd0) && !ph;
    endfunction

    assign last_op   = (elem == 3'd0) || (elem == 3'd5) || phase;
    assign last_addr = is_desc(elem) ? (addr == '0) : (addr == ADDR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            elem  <= '0;
            addr  <= '0;
            phase <= 1'b0;
            drain <= 1'b0;
        end else begin
            state <= n_state;
            elem  <= n_elem;
            addr  <= n_addr;
            phase <= n_phase;
            drain <= n_drain;
        end
    end

    always_comb begin
        n_state = state;
        n_elem  = elem;
        n_addr  = addr;
        n_phase = phase;
        n_drain = drain;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) n_state = S_SETUP;
            end
            S_SETUP: begin
                n_state = S_RUN;
                n_elem  = '0;
                n_addr  = '0;
                n_phase = 1'b0;
                n_drain = 1'b0;
            end
            S_RUN: begin
                if (!last_op) begin
                    n_phase = 1'b1;
                end else begin
                    n_phase = 1'b0;
                    if (!last_addr) begin
                        n_addr = is_desc(elem) ? addr - 1'b1 : addr + 1'b1;
                    end else if (elem == 3'd5) begin
                        n_state = S_DRAIN;
                        n_drain = 1'b0;
                    end else begin
                        n_elem = elem + 3'd1;
                        n_addr = is_desc(elem + 3'd1) ? ADDR_MAX : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain) n_state = S_DONE;
                else       n_drain = 1'b1;
            end
            default: n_state = S_IDLE;
        endcase
    end

    assign n_run = (n_state == S_RUN);
    assign n_rd  = n_run && is_read(n_elem, n_phase);

    // Outputs are registered from the next state so they track elem/addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            men_q  <= 1'b0;
            wen_q  <= 1'b0;
            ren_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            bm_q   <= '0;
        end else begin
            en_q   <= n_state inside {S_SETUP, S_RUN, S_DRAIN};
            busy_q <= n_state inside {S_SETUP, S_RUN, S_DRAIN};
            done_q <= (n_state == S_DONE);
            men_q  <= n_run;
            wen_q  <= n_run && !n_rd;
            ren_q  <= n_rd;
            addr_q <= n_run ? n_addr : '0;
            din_q  <= (n_run && !n_rd && wr_ones(n_elem)) ? ONES : '0;
            bm_q   <= n_run ? ONES : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_exp  <= '0;
            s1_addr <= '0;
            s1_elem <= '0;
        end else begin
            s1_vld  <= ren_q;
            s1_exp  <= rd_ones(elem) ? ONES : '0;
            s1_addr <= addr_q;
            s1_elem <= elem;
        end
    end

    assign mism = s1_vld && (bist.dout != s1_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
        end else if (n_state == S_SETUP) begin
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
        end else if (mism) begin
            fail <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!fail) begin
                fail_addr <= s1_addr;
                fail_elem <= s1_elem;
                fail_data <= bist.dout;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bist.en   = en_q;
    assign bist.men  = men_q;
    assign bist.wen  = wen_q;
    assign bist.ren  = ren_q;
    assign bist.addr = addr_q;
    assign bist.din  = din_q;
    assign bist.bm   = bm_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench: 4-word x 8-bit SRAM model with injectable stuck-at cells
// on the BIST port of sram_march_bist_ctrl.
module tb_sram_march_bist_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy, done, fail;
    logic [15:0] err_cnt;
    logic [1:0]  fail_addr;
    logic [2:0]  fail_elem;
    logic [7:0]  fail_data;

    logic        sa1_en;
    logic        sa0_en;
    int          n_assert;
    int          n_fail;
    int          edges;

    logic [7:0]  mem [4];
    logic [19:0] oplog [$];
    logic [19:0] exp_ops [$];

    sram_march_bist_ctrl_if #(.P_ADDR_WIDTH(2), .P_DATA_WIDTH(8)) bif ();

    sram_march_bist_ctrl #(
        .P_ADDR_WIDTH   (2),
        .P_DATA_WIDTH   (8),
        .P_ERR_CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .err_cnt  (err_cnt),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem),
        .fail_data(fail_data),
        .bist     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input logic [7:0] d, input logic [1:0] a);
        logic [7:0] v;
        v = d;
        if (sa1_en && a == 2'd2) v[3] = 1'b1;
        if (sa0_en && a == 2'd1) v[0] = 1'b0;
        return v;
    endfunction

    // Macro port: registered read data, X outside read slots.
    always @(posedge clk) begin
        if (bif.men && bif.wen)
            mem[bif.addr] <= (mem[bif.addr] & ~bif.bm) | (bif.din & bif.bm);
        if (bif.men && bif.ren) bif.dout <= faulty(mem[bif.addr], bif.addr);
        else                    bif.dout <= 'x;
        if (bif.men)
            oplog.push_back({bif.wen, bif.ren, bif.addr, bif.din, bif.bm});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse (or hold) START, count edges after the sampling edge until DONE.
    task automatic run(input bit hold, input int glitch, output int cnt);
        cnt   = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        while (!done && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!hold) start = (cnt == glitch);
        end
        start = hold;
    endtask

    initial begin
        logic [7:0] wd [6];
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sa1_en   = 1'b0;
        sa0_en   = 1'b0;
        wd[0] = 8'h00; wd[1] = 8'hFF; wd[2] = 8'h00;
        wd[3] = 8'hFF; wd[4] = 8'h00; wd[5] = 8'h00;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 4; i++) begin
                logic [1:0] a;
                a = (e == 3 || e == 4) ? 2'(3 - i) : 2'(i);
                if (e != 0) exp_ops.push_back({1'b0, 1'b1, a, 8'h00, 8'hFF});
                if (e != 5) exp_ops.push_back({1'b1, 1'b0, a, wd[e], 8'hFF});
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en",   32'(bif.en), 0);
        chk("rst_men",  32'(bif.men), 0);
        chk("rst_bm",   32'(bif.bm), 0);
        chk("rst_err",  32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        oplog.delete();
        run(1'b0, -1, edges);
        chk("clean_edges", 32'(edges), 43);
        chk("clean_fail",  32'(fail), 0);
        chk("clean_err",   32'(err_cnt), 0);
        chk("clean_en",    32'(bif.en), 0);
        chk("clean_busy",  32'(busy), 0);
        chk("clean_nops",  32'(oplog.size()), 40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("op%0d", i), 32'(i < oplog.size() ? oplog[i] : 20'h0), 32'(exp_ops[i]));
        repeat (3) @(posedge clk);
        #1;
        chk("done_level", 32'(done), 1);

        sa1_en = 1'b1;
        run(1'b0, -1, edges);
        chk("sa1_edges", 32'(edges), 43);
        chk("sa1_fail",  32'(fail), 1);
        chk("sa1_addr",  32'(fail_addr), 2);
        chk("sa1_elem",  32'(fail_elem), 1);
        chk("sa1_data",  32'(fail_data), 32'h08);
        chk("sa1_err",   32'(err_cnt), 3);

        sa1_en = 1'b0;
        sa0_en = 1'b1;
        run(1'b0, -1, edges);
        chk("sa0_fail", 32'(fail), 1);
        chk("sa0_addr", 32'(fail_addr), 1);
        chk("sa0_elem", 32'(fail_elem), 2);
        chk("sa0_data", 32'(fail_data), 32'hFE);
        chk("sa0_err",  32'(err_cnt), 2);

        sa1_en = 1'b1;
        run(1'b0, -1, edges);
        chk("two_addr", 32'(fail_addr), 2);
        chk("two_elem", 32'(fail_elem), 1);
        chk("two_data", 32'(fail_data), 32'h08);
        chk("two_err",  32'(err_cnt), 5);

        sa1_en = 1'b0;
        sa0_en = 1'b0;
        run(1'b0, 10, edges);
        chk("glitch_edges", 32'(edges), 43);
        chk("glitch_err",   32'(err_cnt), 0);

        sa1_en = 1'b1;
        run(1'b1, -1, edges);
        chk("hold_edges1", 32'(edges), 43);
        chk("hold_err1",   32'(err_cnt), 3);
        @(posedge clk);
        #1;
        chk("hold_busy", 32'(busy), 1);
        chk("hold_done", 32'(done), 0);
        chk("hold_en",   32'(bif.en), 1);
        chk("hold_men",  32'(bif.men), 0);
        chk("hold_fail", 32'(fail), 0);
        chk("hold_clr",  32'(err_cnt), 0);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("hold_edges2", 32'(edges), 43);
        chk("hold_err2",   32'(err_cnt), 3);
        @(negedge clk);

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        chk("e3_men",  32'(bif.men), 1);
        chk("e3_fail", 32'(fail), 1);
        chk("e3_err",  32'(err_cnt), 1);
        rst = 1'b1;
        #1;
        chk("arst_en",   32'(bif.en), 0);
        chk("arst_men",  32'(bif.men), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_fail", 32'(fail), 0);
        chk("arst_err",  32'(err_cnt), 0);
        chk("arst_elem", 32'(fail_elem), 0);
        chk("arst_addr", 32'(fail_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_en",   32'(bif.en), 0);
        chk("idle_done", 32'(done), 0);
        run(1'b0, -1, edges);
        chk("rerun_edges", 32'(edges), 43);
        chk("rerun_err",   32'(err_cnt), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
